// File: rtl/npu_mc_channel_arbiter.sv
// Multi-channel front end: round-robin request arbitration onto one MC port,
// sender-steered responses into per-channel FWFT FIFOs with credit-based flow control.
module npu_mc_channel_arbiter #(
    parameter int unsigned NUM_CH           = 2,
    parameter int unsigned MEM_ADDR_w       = 32,
    parameter int unsigned MEM_DATA_BLOCK_w = 512,
    parameter int unsigned NODE_ID_w        = 10,
    parameter int unsigned FIFO_DEPTH       = 4
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NUM_CH-1:0]                          ch_req_read_i,
    input  logic [NUM_CH-1:0]                          ch_req_write_i,
    input  logic [NUM_CH-1:0][MEM_ADDR_w-1:0]          ch_req_address_i,
    input  logic [NUM_CH-1:0][63:0]                    ch_req_dirty_mask_i,
    input  logic [NUM_CH-1:0][MEM_DATA_BLOCK_w-1:0]    ch_req_data_i,
    output logic [NUM_CH-1:0]                          ch_read_avail_o,
    output logic [NUM_CH-1:0]                          ch_write_avail_o,
    output logic [NUM_CH-1:0]                          ch_resp_valid_o,
    output logic [NUM_CH-1:0][MEM_ADDR_w-1:0]          ch_resp_address_o,
    output logic [NUM_CH-1:0][MEM_DATA_BLOCK_w-1:0]    ch_resp_data_o,
    input  logic [NUM_CH-1:0]                          ch_resp_ready_i,
    output logic [MEM_ADDR_w-1:0]                      mc_address_o,
    output logic [63:0]                                mc_dirty_mask_o,
    output logic [MEM_DATA_BLOCK_w-1:0]                mc_block_o,
    output logic                                       mc_read_o,
    output logic                                       mc_write_o,
    output logic [NODE_ID_w-1:0]                       mc_sender_o,
    input  logic                                       mc_read_avail_i,
    input  logic                                       mc_write_avail_i,
    input  logic                                       mc_valid_i,
    input  logic [MEM_ADDR_w-1:0]                      mc_address_i,
    input  logic [MEM_DATA_BLOCK_w-1:0]                mc_block_i,
    input  logic [NODE_ID_w-1:0]                       mc_sender_i,
    output logic                                       mc_avail_o,
    output logic                                       err_o
);

    localparam int unsigned CH_w  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_w = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_w = $clog2(FIFO_DEPTH);

    // active_q is 0 in the cycle after any reset edge, so all avails read 0 then
    logic                        active_q;
    logic [CH_w-1:0]             rr_ptr_q, rr_ptr_d;
    logic                        err_q, err_d;
    logic                        mc_read_q, mc_read_d, mc_write_q, mc_write_d;
    logic [MEM_ADDR_w-1:0]       mc_addr_q, mc_addr_d;
    logic [63:0]                 mc_mask_q, mc_mask_d;
    logic [MEM_DATA_BLOCK_w-1:0] mc_blk_q, mc_blk_d;
    logic [NODE_ID_w-1:0]        mc_snd_q, mc_snd_d;

    logic [NUM_CH-1:0]             wr_elig, rd_elig, credit_nz;
    logic [NUM_CH-1:0][CNT_w-1:0]  occ_all, outst_all;
    logic                          win_found, win_is_write, acc_read, acc_write;
    logic [CH_w-1:0]               win_idx, arb_idx;
    logic [CH_w:0]                 arb_sum;

    logic            resp_fire, sender_ok, sel_outst_nz, sel_full, sel_pop;
    logic            resp_take, resp_push;
    logic [CH_w-1:0] sender_idx;

    // Round-robin search for the first eligible channel at or after rr_ptr_q
    always_comb begin
        win_found    = 1'b0;
        win_is_write = 1'b0;
        win_idx      = '0;
        arb_sum      = '0;
        arb_idx      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            arb_sum = {1'b0, rr_ptr_q} + (CH_w+1)'(i);
            if (arb_sum >= (CH_w+1)'(NUM_CH)) arb_sum = arb_sum - (CH_w+1)'(NUM_CH);
            arb_idx = arb_sum[CH_w-1:0];
            if (!win_found && (wr_elig[arb_idx] || rd_elig[arb_idx])) begin
                win_found    = 1'b1;
                win_idx      = arb_idx;
                win_is_write = wr_elig[arb_idx];
            end
        end
    end

    assign acc_read  = win_found & ~win_is_write;
    assign acc_write = win_found & win_is_write;

    // Only the winner's matching avail bit is raised
    always_comb begin
        ch_read_avail_o  = '0;
        ch_write_avail_o = '0;
        if (acc_write) ch_write_avail_o[win_idx] = 1'b1;
        if (acc_read)  ch_read_avail_o[win_idx]  = 1'b1;
    end

    // Response decode; a full-FIFO push is only legal alongside a pop
    assign resp_fire    = mc_valid_i & active_q;
    assign sender_ok    = mc_sender_i < NODE_ID_w'(NUM_CH);
    assign sender_idx   = mc_sender_i[CH_w-1:0];
    assign sel_outst_nz = outst_all[sender_idx] != '0;
    assign sel_full     = occ_all[sender_idx] == CNT_w'(FIFO_DEPTH);
    assign sel_pop      = ch_resp_valid_o[sender_idx] & ch_resp_ready_i[sender_idx];
    assign resp_take    = resp_fire & sender_ok & sel_outst_nz;
    assign resp_push    = resp_take & (~sel_full | sel_pop);

    // Next-state for pointer, error flag and the registered MC request
    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        err_d      = err_q | (resp_fire & ~resp_push);
        mc_read_d  = acc_read;
        mc_write_d = acc_write;
        mc_addr_d  = mc_addr_q;
        mc_mask_d  = mc_mask_q;
        mc_blk_d   = mc_blk_q;
        mc_snd_d   = mc_snd_q;
        if (win_found) begin
            rr_ptr_d  = (win_idx == CH_w'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
            mc_addr_d = ch_req_address_i[win_idx];
            mc_mask_d = ch_req_dirty_mask_i[win_idx];
            mc_blk_d  = ch_req_data_i[win_idx];
            mc_snd_d  = NODE_ID_w'(win_idx);
        end
    end

    // Shared state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            active_q   <= 1'b0;
            rr_ptr_q   <= '0;
            err_q      <= 1'b0;
            mc_read_q  <= 1'b0;
            mc_write_q <= 1'b0;
            mc_addr_q  <= '0;
            mc_mask_q  <= '0;
            mc_blk_q   <= '0;
            mc_snd_q   <= '0;
        end else begin
            active_q   <= 1'b1;
            rr_ptr_q   <= rr_ptr_d;
            err_q      <= err_d;
            mc_read_q  <= mc_read_d;
            mc_write_q <= mc_write_d;
            mc_addr_q  <= mc_addr_d;
            mc_mask_q  <= mc_mask_d;
            mc_blk_q   <= mc_blk_d;
            mc_snd_q   <= mc_snd_d;
        end
    end

    assign mc_read_o       = mc_read_q;
    assign mc_write_o      = mc_write_q;
    assign mc_address_o    = mc_addr_q;
    assign mc_dirty_mask_o = mc_mask_q;
    assign mc_block_o      = mc_blk_q;
    assign mc_sender_o     = mc_snd_q;
    assign mc_avail_o      = active_q;
    assign err_o           = err_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_w-1:0]            occ_q, occ_d, outst_q, outst_d;
        logic [PTR_w-1:0]            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
        logic [MEM_ADDR_w-1:0]       addr_mem_q [FIFO_DEPTH];
        logic [MEM_DATA_BLOCK_w-1:0] data_mem_q [FIFO_DEPTH];
        logic                        push, pop, issue, take;
        logic [CNT_w:0]              credit;

        assign push   = resp_push & (sender_idx == CH_w'(c));
        assign take   = resp_take & (sender_idx == CH_w'(c));
        assign pop    = ch_resp_valid_o[c] & ch_resp_ready_i[c];
        assign issue  = acc_read & (win_idx == CH_w'(c));
        // Registered occupancy only: no ready-to-avail combinational path
        assign credit = (CNT_w+1)'(FIFO_DEPTH) - {1'b0, occ_q} - {1'b0, outst_q};

        assign credit_nz[c] = credit != '0;
        assign occ_all[c]   = occ_q;
        assign outst_all[c] = outst_q;
        assign wr_elig[c]   = active_q & ch_req_write_i[c] & mc_write_avail_i;
        assign rd_elig[c]   = active_q & ch_req_read_i[c] & ~ch_req_write_i[c] &
                              mc_read_avail_i & credit_nz[c];

        assign ch_resp_valid_o[c]   = occ_q != '0;
        assign ch_resp_address_o[c] = ch_resp_valid_o[c] ? addr_mem_q[rd_ptr_q] : '0;
        assign ch_resp_data_o[c]    = ch_resp_valid_o[c] ? data_mem_q[rd_ptr_q] : '0;

        // Counters and wrap-around pointers; depth need not be a power of two
        always_comb begin
            occ_d    = occ_q;
            outst_d  = outst_q;
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            case ({push, pop})
                2'b10:   occ_d = occ_q + 1'b1;
                2'b01:   occ_d = occ_q - 1'b1;
                default: occ_d = occ_q;
            endcase
            case ({issue, take})
                2'b10:   outst_d = outst_q + 1'b1;
                2'b01:   outst_d = outst_q - 1'b1;
                default: outst_d = outst_q;
            endcase
            if (pop)  rd_ptr_d = (rd_ptr_q == PTR_w'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            if (push) wr_ptr_d = (wr_ptr_q == PTR_w'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end

        // Per-channel FIFO control state
        always_ff @(posedge clk) begin
            if (!reset) begin
                occ_q    <= '0;
                outst_q  <= '0;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                occ_q    <= occ_d;
                outst_q  <= outst_d;
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
            end
        end

        // FIFO storage; contents are masked at the outputs while empty
        always_ff @(posedge clk) begin
            if (push) begin
                addr_mem_q[wr_ptr_q] <= mc_address_i;
                data_mem_q[wr_ptr_q] <= mc_block_i;
            end
        end
    end

endmodule

// File: tb/tb_npu_mc_channel_arbiter.sv
// Directed bench for npu_mc_channel_arbiter: vector table for arbitration plus
// hand-written sequences for steering, credit, errors and mid-operation reset.
module tb_npu_mc_channel_arbiter;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            ch_req_read_i, ch_req_write_i;
    logic [1:0][31:0]      ch_req_address_i;
    logic [1:0][63:0]      ch_req_dirty_mask_i;
    logic [1:0][511:0]     ch_req_data_i;
    logic [1:0]            ch_read_avail_o, ch_write_avail_o, ch_resp_valid_o;
    logic [1:0][31:0]      ch_resp_address_o;
    logic [1:0][511:0]     ch_resp_data_o;
    logic [1:0]            ch_resp_ready_i;
    logic [31:0]           mc_address_o;
    logic [63:0]           mc_dirty_mask_o;
    logic [511:0]          mc_block_o;
    logic                  mc_read_o, mc_write_o;
    logic [9:0]            mc_sender_o;
    logic                  mc_read_avail_i, mc_write_avail_i, mc_valid_i;
    logic [31:0]           mc_address_i;
    logic [511:0]          mc_block_i;
    logic [9:0]            mc_sender_i;
    logic                  mc_avail_o, err_o;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    npu_mc_channel_arbiter dut (
        .clk                 (clk),
        .reset               (reset),
        .ch_req_read_i       (ch_req_read_i),
        .ch_req_write_i      (ch_req_write_i),
        .ch_req_address_i    (ch_req_address_i),
        .ch_req_dirty_mask_i (ch_req_dirty_mask_i),
        .ch_req_data_i       (ch_req_data_i),
        .ch_read_avail_o     (ch_read_avail_o),
        .ch_write_avail_o    (ch_write_avail_o),
        .ch_resp_valid_o     (ch_resp_valid_o),
        .ch_resp_address_o   (ch_resp_address_o),
        .ch_resp_data_o      (ch_resp_data_o),
        .ch_resp_ready_i     (ch_resp_ready_i),
        .mc_address_o        (mc_address_o),
        .mc_dirty_mask_o     (mc_dirty_mask_o),
        .mc_block_o          (mc_block_o),
        .mc_read_o           (mc_read_o),
        .mc_write_o          (mc_write_o),
        .mc_sender_o         (mc_sender_o),
        .mc_read_avail_i     (mc_read_avail_i),
        .mc_write_avail_i    (mc_write_avail_i),
        .mc_valid_i          (mc_valid_i),
        .mc_address_i        (mc_address_i),
        .mc_block_i          (mc_block_i),
        .mc_sender_i         (mc_sender_i),
        .mc_avail_o          (mc_avail_o),
        .err_o               (err_o)
    );

    typedef struct {
        logic [1:0]  rd;
        logic [1:0]  wr;
        logic        rav;
        logic        wav;
        logic [1:0]  exp_ravail;
        logic [1:0]  exp_wavail;
        logic        exp_rd;
        logic        exp_wr;
        logic [9:0]  exp_snd;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        ch_req_read_i    = '0;
        ch_req_write_i   = '0;
        ch_resp_ready_i  = '0;
        mc_read_avail_i  = 1'b1;
        mc_write_avail_i = 1'b1;
        mc_valid_i       = 1'b0;
        mc_address_i     = '0;
        mc_block_i       = '0;
        mc_sender_i      = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic resp(input logic [9:0] snd, input logic [31:0] addr, input logic [31:0] word);
        mc_valid_i   = 1'b1;
        mc_sender_i  = snd;
        mc_address_i = addr;
        mc_block_i   = {16{word}};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ch0 -> 0x100, ch1 -> 0x200; data/mask tagged with the channel
        ch_req_address_i[0]    = 32'h100;
        ch_req_address_i[1]    = 32'h200;
        ch_req_data_i[0]       = {16{32'hDA7A_0000}};
        ch_req_data_i[1]       = {16{32'hDA7A_0001}};
        ch_req_dirty_mask_i[0] = 64'h5A5A_0000_0000_0000;
        ch_req_dirty_mask_i[1] = 64'h5A5A_0000_0000_0001;

        //             rd     wr    rav   wav   ravail wavail rd    wr    snd   addr
        vecs[0] = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 10'd0, 32'h000};
        vecs[1] = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 10'd0, 32'h100};
        vecs[2] = '{2'b11, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 10'd1, 32'h200};
        vecs[3] = '{2'b00, 2'b11, 1'b1, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0, 10'd0, 32'h100};
        vecs[4] = '{2'b01, 2'b01, 1'b1, 1'b1, 2'b00, 2'b01, 1'b0, 1'b1, 10'd1, 32'h200};
        vecs[5] = '{2'b11, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 10'd0, 32'h100};
        vecs[6] = '{2'b11, 2'b10, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 10'd0, 32'h100};
        vecs[7] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 10'd0, 32'h100};
        vecs[8] = '{2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 10'd0, 32'h100};

        // Reset held two cycles under random inputs
        reset            = 1'b0;
        ch_req_read_i    = 2'($urandom);
        ch_req_write_i   = 2'($urandom);
        ch_resp_ready_i  = 2'($urandom);
        mc_read_avail_i  = 1'($urandom);
        mc_write_avail_i = 1'($urandom);
        mc_valid_i       = 1'($urandom);
        mc_address_i     = $urandom;
        mc_block_i       = {16{$urandom}};
        mc_sender_i      = 10'($urandom);
        repeat (2) @(negedge clk);
        #1;
        chk("rst_read_avail", 64'(ch_read_avail_o), 64'd0);
        chk("rst_write_avail", 64'(ch_write_avail_o), 64'd0);
        chk("rst_resp_valid", 64'(ch_resp_valid_o), 64'd0);
        chk("rst_mc_rd_wr", {62'd0, mc_read_o, mc_write_o}, 64'd0);
        chk("rst_mc_addr", 64'(mc_address_o), 64'd0);
        chk("rst_mc_sender", 64'(mc_sender_o), 64'd0);
        chk("rst_mc_avail", 64'(mc_avail_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        idle();
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk("rel_mc_avail", 64'(mc_avail_o), 64'd1);
        chk("rel_err", 64'(err_o), 64'd0);

        // Arbitration vectors; mc_* reflect the previous row's acceptance
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            ch_req_read_i    = vecs[i].rd;
            ch_req_write_i   = vecs[i].wr;
            mc_read_avail_i  = vecs[i].rav;
            mc_write_avail_i = vecs[i].wav;
            #1;
            chk($sformatf("v%0d_read_avail", i), 64'(ch_read_avail_o), 64'(vecs[i].exp_ravail));
            chk($sformatf("v%0d_write_avail", i), 64'(ch_write_avail_o), 64'(vecs[i].exp_wavail));
            chk($sformatf("v%0d_mc_read", i), 64'(mc_read_o), 64'(vecs[i].exp_rd));
            chk($sformatf("v%0d_mc_write", i), 64'(mc_write_o), 64'(vecs[i].exp_wr));
            chk($sformatf("v%0d_mc_sender", i), 64'(mc_sender_o), 64'(vecs[i].exp_snd));
            chk($sformatf("v%0d_mc_addr", i), 64'(mc_address_o), 64'(vecs[i].exp_addr));
            if (vecs[i].exp_wr) begin
                chk($sformatf("v%0d_mc_block", i), 64'(mc_block_o[31:0]),
                    64'(32'hDA7A_0000 + 32'(vecs[i].exp_snd)));
                chk($sformatf("v%0d_mc_mask", i), mc_dirty_mask_o,
                    64'h5A5A_0000_0000_0000 + 64'(vecs[i].exp_snd));
            end
        end

        // Out-of-order steering: outstanding is ch0=3, ch1=1
        @(negedge clk);
        resp(10'd1, 32'h200, 32'hAAAA_0001);
        #1;
        chk("steer_mc_avail", 64'(mc_avail_o), 64'd1);
        @(negedge clk);
        resp(10'd0, 32'h100, 32'hBBBB_0000);
        #1;
        chk("steer1_valid", 64'(ch_resp_valid_o), 64'b10);
        chk("steer1_data", 64'(ch_resp_data_o[1][31:0]), 64'hAAAA_0001);
        chk("steer1_addr", 64'(ch_resp_address_o[1]), 64'h200);
        @(negedge clk);
        mc_valid_i = 1'b0;
        #1;
        chk("steer0_valid", 64'(ch_resp_valid_o), 64'b11);
        chk("steer0_data", 64'(ch_resp_data_o[0][31:0]), 64'hBBBB_0000);
        chk("steer0_addr", 64'(ch_resp_address_o[0]), 64'h100);
        chk("steer_err", 64'(err_o), 64'd0);

        // Response to ch1 with nothing outstanding: dropped, error
        @(negedge clk);
        resp(10'd1, 32'h200, 32'hDEAD_0001);
        @(negedge clk);
        mc_valid_i      = 1'b0;
        ch_resp_ready_i = 2'b10;
        #1;
        chk("noout_err", 64'(err_o), 64'd1);
        @(negedge clk);
        ch_resp_ready_i = 2'b00;
        #1;
        chk("noout_dropped", 64'(ch_resp_valid_o), 64'b01);

        // Out-of-range sender after a fresh reset
        do_reset();
        #1;
        chk("rst2_err", 64'(err_o), 64'd0);
        chk("rst2_valid", 64'(ch_resp_valid_o), 64'd0);
        @(negedge clk);
        resp(10'd3, 32'h300, 32'hDEAD_0003);
        @(negedge clk);
        mc_valid_i = 1'b0;
        #1;
        chk("badsnd_err", 64'(err_o), 64'd1);
        chk("badsnd_valid", 64'(ch_resp_valid_o), 64'd0);
        repeat (3) @(negedge clk);
        #1;
        chk("badsnd_sticky", 64'(err_o), 64'd1);

        // Credit exhaustion on ch0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            ch_req_read_i = 2'b01;
            #1;
            chk($sformatf("cred_issue%0d", k), 64'(ch_read_avail_o), 64'b01);
            if (k > 0) chk($sformatf("cred_mcrd%0d", k), 64'(mc_read_o), 64'd1);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            resp(10'd0, 32'h1000 + 32'(k), 32'hC0DE_0000 + 32'(k));
            #1;
            chk($sformatf("cred_block%0d", k), 64'(ch_read_avail_o), 64'b00);
            if (k > 0) chk($sformatf("cred_head%0d", k), 64'(ch_resp_data_o[0][31:0]),
                           64'hC0DE_0000);
        end
        @(negedge clk);
        mc_valid_i      = 1'b0;
        ch_resp_ready_i = 2'b01;
        #1;
        chk("cred_full_noavail", 64'(ch_read_avail_o), 64'b00);
        chk("cred_full_valid", 64'(ch_resp_valid_o), 64'b01);
        @(negedge clk);
        ch_resp_ready_i = 2'b00;
        #1;
        chk("cred_after_pop", 64'(ch_read_avail_o), 64'b01);
        chk("cred_head_next", 64'(ch_resp_data_o[0][31:0]), 64'hC0DE_0001);
        @(negedge clk);
        ch_req_read_i   = 2'b00;
        ch_resp_ready_i = 2'b01;
        #1;
        chk("cred_5th_mcrd", 64'(mc_read_o), 64'd1);
        chk("cred_5th_addr", 64'(mc_address_o), 64'h100);

        // Drain to one entry, then issue + push + pop in the same cycle
        @(negedge clk);
        #1;
        chk("sim_head_r2", 64'(ch_resp_data_o[0][31:0]), 64'hC0DE_0002);
        @(negedge clk);
        ch_req_read_i = 2'b01;
        resp(10'd0, 32'h3000, 32'h5111_0000);
        #1;
        chk("sim_avail", 64'(ch_read_avail_o), 64'b01);
        chk("sim_head_r3", 64'(ch_resp_data_o[0][31:0]), 64'hC0DE_0003);
        @(negedge clk);
        ch_req_read_i   = 2'b00;
        ch_resp_ready_i = 2'b00;
        resp(10'd0, 32'h4000, 32'h5222_0000);
        #1;
        chk("sim_valid", 64'(ch_resp_valid_o), 64'b01);
        chk("sim_head_x", 64'(ch_resp_data_o[0][31:0]), 64'h5111_0000);
        chk("sim_mcrd", 64'(mc_read_o), 64'd1);
        chk("sim_err", 64'(err_o), 64'd0);
        @(negedge clk);
        mc_valid_i = 1'b0;
        #1;
        chk("sim_outst_kept", 64'(err_o), 64'd0);
        chk("sim_head_still_x", 64'(ch_resp_address_o[0]), 64'h3000);

        // Mid-operation reset with two entries buffered
        reset         = 1'b0;
        ch_req_read_i = 2'b01;
        @(negedge clk);
        #1;
        chk("mid_valid", 64'(ch_resp_valid_o), 64'd0);
        chk("mid_read_avail", 64'(ch_read_avail_o), 64'd0);
        chk("mid_mc_avail", 64'(mc_avail_o), 64'd0);
        chk("mid_mcrd", 64'(mc_read_o), 64'd0);
        reset         = 1'b1;
        ch_req_read_i = 2'b00;
        @(negedge clk);
        resp(10'd0, 32'h5000, 32'h1A7E_0000);
        #1;
        chk("late_mc_avail", 64'(mc_avail_o), 64'd1);
        chk("late_err_before", 64'(err_o), 64'd0);
        @(negedge clk);
        mc_valid_i = 1'b0;
        #1;
        chk("late_err", 64'(err_o), 64'd1);
        chk("late_valid", 64'(ch_resp_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/npu_mc_channel_arbiter.md
# npu_mc_channel_arbiter

- Multi-channel front end between `NUM_CH` `tile_mc` instances and one external memory controller port, so a mesh can host several memory tiles.
- Request path: round-robin arbitration of read/write requests onto a single registered MC request port, tagging each with its channel index as sender.
- Response path: MC responses are steered by sender into per-channel FIFOs.
- Credit accounting guarantees no FIFO overflow.

## Interface

Parameters:
- `NUM_CH`, 2: number of MC channels (≥1). `CH_w = max(1, $clog2(NUM_CH))`.
- `MEM_ADDR_w`, 32: address width.
- `MEM_DATA_BLOCK_w`, 512: data block width.
- `NODE_ID_w`, 10: sender field width (≥ `CH_w`).
- `FIFO_DEPTH`, 4: response FIFO entries per channel (≥2). `CNT_w = $clog2(FIFO_DEPTH+1)`.

Ports (per-channel buses are packed `[NUM_CH-1:0][W-1:0]`):
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-low.
- `ch_req_read_i` in NUM_CH: channel read request.
- `ch_req_write_i` in NUM_CH: channel write request.
- `ch_req_address_i` in NUM_CH×MEM_ADDR_w: request address.
- `ch_req_dirty_mask_i` in NUM_CH×64: write dirty mask.
- `ch_req_data_i` in NUM_CH×MEM_DATA_BLOCK_w: write block.
- `ch_read_avail_o` out NUM_CH: read accepted this cycle if asserted with `ch_req_read_i`.
- `ch_write_avail_o` out NUM_CH: same, for writes.
- `ch_resp_valid_o` out NUM_CH: FIFO head valid.
- `ch_resp_address_o` out NUM_CH×MEM_ADDR_w: head address.
- `ch_resp_data_o` out NUM_CH×MEM_DATA_BLOCK_w: head data.
- `ch_resp_ready_i` in NUM_CH: pop head.
- `mc_address_o` out MEM_ADDR_w: request address.
- `mc_dirty_mask_o` out 64: request dirty mask.
- `mc_block_o` out MEM_DATA_BLOCK_w: request data.
- `mc_read_o` out 1: one-cycle read pulse.
- `mc_write_o` out 1: one-cycle write pulse.
- `mc_sender_o` out NODE_ID_w: channel index, zero-extended.
- `mc_read_avail_i` in 1: MC can take a read.
- `mc_write_avail_i` in 1: MC can take a write.
- `mc_valid_i` in 1: response valid.
- `mc_address_i` in MEM_ADDR_w: response address.
- `mc_block_i` in MEM_DATA_BLOCK_w: response data.
- `mc_sender_i` in NODE_ID_w: response destination channel.
- `mc_avail_o` out 1: response port ready.
- `err_o` out 1: sticky protocol error.

## Operation

- **Eligibility.** Channel c is eligible for write when `ch_req_write_i[c] & mc_write_avail_i`. It is eligible for read when `ch_req_read_i[c] & ~ch_req_write_i[c] & mc_read_avail_i & credit[c]>0`.
- **Read/write priority.** If a channel asserts both read and write, the write wins; the read stays pending.
- **Credit.** `credit[c] = FIFO_DEPTH − occupancy[c] − outstanding[c]`, computed at `CNT_w+1` bits, never negative.
- **Arbitration.** Combinational round-robin from `rr_ptr`: the winner is the first eligible channel at or after `rr_ptr`, cyclic. Only the winner's matching avail bit is high; all others are 0.
- **Pointer update.** On acceptance, `rr_ptr <= (winner+1) mod NUM_CH`. With no acceptance, `rr_ptr` holds.
- **Accepted request.** Registered into the mc_* request outputs next cycle. `mc_read_o`/`mc_write_o` pulse for exactly one cycle; address, data and mask hold their last value otherwise.
- **Outstanding count.** An accepted read increments `outstanding[winner]`.
- **Response acceptance.** On `mc_valid_i & mc_avail_o`:
  - `mc_sender_i < NUM_CH` and `outstanding[s] > 0`: push {address, data} into FIFO s and decrement `outstanding[s]`.
  - Otherwise: drop the response and set `err_o`.
- **Simultaneous events.** Issue and response on the same channel in the same cycle: `outstanding` is unchanged net. Push and pop on the same FIFO in the same cycle: occupancy is unchanged. A push into a full FIFO plus a pop is legal.
- **Response outputs.** FIFOs are first-word fall-through: `ch_resp_valid_o[c] = occupancy[c] != 0`. A pop occurs on `valid & ready`. Read/write pointers wrap modulo `FIFO_DEPTH`, which need not be a power of two.
- **`mc_avail_o`.** Equals 1 out of reset. Credit accounting makes overflow impossible; a push to a full FIFO (unreachable) is dropped and sets `err_o`.

## Timing

- **Reset** (`reset==0` at a clk edge) clears everything, including mid-operation:
  - All outputs go to 0, including `mc_avail_o`, `err_o` and avail bits.
  - FIFOs are emptied; `outstanding` and `rr_ptr` are cleared.
  - In-flight MC responses arriving after reset release find `outstanding==0`; they are dropped and set `err_o`.
- **Request latency:** 1 cycle from channel acceptance (cycle t) to `mc_read_o`/`mc_write_o` (cycle t+1).
- **Throughput:** one request per cycle.
- **Response latency:** push at edge t means `ch_resp_valid_o` is high in cycle t+1. A pop at the edge exposes the next entry in the following cycle.
- **Avail bits** are combinational from the `ch_req_*`, `mc_*_avail_i`, `rr_ptr` and credit registers. There is no combinational path from `ch_resp_ready_i` to `ch_read_avail_o`; credit uses registered occupancy.

## Test plan

1. **Reset.** Hold `reset=0` for 2 cycles with random inputs → every output is 0. After release: `mc_avail_o=1`, `err_o=0`, credit=4 for each channel.
2. **Round-robin.** NUM_CH=2; both channels read (0x100, 0x200) continuously with MC avail → `mc_read_o` in consecutive cycles, sender 0 then 1, alternating. Address matches the sender.
3. **Out-of-order response steering.** Responses arrive sender 1 (data 0xA…) then sender 0 (0xB…) → `ch_resp_valid_o[1]` is high the cycle after the first response with data 0xA; `ch_resp_valid_o[0]` follows with data 0xB. Other channels' valids stay 0.
4. **Credit exhaustion.** FIFO_DEPTH=4; ch0 issues 4 reads, 4 responses return, `ch_resp_ready_i[0]=0` → `ch_read_avail_o[0]=0` on the 5th request. One pop → the 5th read is issued the next cycle.
5. **Protocol errors.**
   - `mc_sender_i=3` with NUM_CH=2 → response dropped, `err_o=1`, held until reset.
   - A response to a channel with `outstanding==0` behaves identically.
6. **Simultaneous events, then mid-operation reset.**
   - Issue, push and pop on the same channel in one cycle → counts are unchanged.
   - Then assert `reset` with 2 entries buffered → FIFOs are empty and the avails are 0 in the following cycle. A late response then sets `err_o`.
